// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, stall, flush and data-wait controller
module hazard_ctrl #(
    parameter logic [7:0] DMEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       imem_ack,
    input  logic       mem_req,
    input  logic       dmem_ack,
    input  logic [3:0] wb_exc,
    input  logic       wb_xret,
    output logic       stall_if,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       stall_exmem,
    output logic       clear_ifid,
    output logic       clear_idex,
    output logic       clear_exmem,
    output logic       clear_memwb,
    output logic [1:0] pc_sel,
    output logic       dmem_abort,
    output logic       bus_err
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;
    localparam logic [1:0] PC_EPC    = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wcnt;
    logic [7:0] wcnt_nxt;

    logic trap;
    logic load_use;

    assign trap     = (wb_exc != 4'd0) || wb_xret;
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state and hazard outputs, evaluated in priority order
    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        stall_if    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        clear_exmem = 1'b0;
        clear_memwb = 1'b0;
        pc_sel      = PC_PLUS4;
        dmem_abort  = 1'b0;
        bus_err     = 1'b0;

        if (rst) begin
            // Bubble the whole pipeline while reset is held
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            clear_memwb = 1'b1;
            state_nxt   = RUN;
            wcnt_nxt    = 8'd0;
        end else if (state == FLUSH) begin
            // Drop the fetch that raced the redirect; trap inputs still show
            // the flushed instruction, so they are ignored here
            clear_ifid = 1'b1;
            state_nxt  = RUN;
            wcnt_nxt   = 8'd0;
        end else if (trap) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            clear_memwb = 1'b1;
            pc_sel      = (wb_exc != 4'd0) ? PC_TRAP : PC_EPC;
            dmem_abort  = mem_req;
            state_nxt   = FLUSH;
            wcnt_nxt    = 8'd0;
        end else if (state == DWAIT) begin
            if (dmem_ack) begin
                // Access completes: let the whole pipeline advance
                state_nxt = RUN;
                wcnt_nxt  = 8'd0;
            end else if (wcnt == DMEM_TIMEOUT) begin
                bus_err     = 1'b1;
                dmem_abort  = 1'b1;
                clear_ifid  = 1'b1;
                clear_idex  = 1'b1;
                clear_exmem = 1'b1;
                clear_memwb = 1'b1;
                pc_sel      = PC_TRAP;
                state_nxt   = FLUSH;
                wcnt_nxt    = 8'd0;
            end else begin
                stall_if    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
                clear_memwb = 1'b1;
                wcnt_nxt    = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
            end
        end else begin
            if (mem_req && !dmem_ack) begin
                stall_if    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
                clear_memwb = 1'b1;
                state_nxt   = DWAIT;
                wcnt_nxt    = 8'd1;
            end else if (ex_branch_taken) begin
                // Redirect wins over load-use and fetch miss; PC must not hold
                clear_ifid = 1'b1;
                clear_idex = 1'b1;
                pc_sel     = PC_BRANCH;
            end else if (load_use) begin
                stall_if   = 1'b1;
                stall_ifid = 1'b1;
                clear_idex = 1'b1;
            end else if (!imem_ack) begin
                stall_if   = 1'b1;
                clear_ifid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       imem_ack;
    logic       mem_req;
    logic       dmem_ack;
    logic [3:0] wb_exc;
    logic       wb_xret;
    logic       stall_if;
    logic       stall_ifid;
    logic       stall_idex;
    logic       stall_exmem;
    logic       clear_ifid;
    logic       clear_idex;
    logic       clear_exmem;
    logic       clear_memwb;
    logic [1:0] pc_sel;
    logic       dmem_abort;
    logic       bus_err;

    int total;
    int bad;

    // {stalls if,ifid,idex,exmem}_{clears ifid,idex,exmem,memwb}_pc_sel_abort_buserr
    localparam logic [11:0] O_IDLE  = 12'b0000_0000_00_0_0;
    localparam logic [11:0] O_RST   = 12'b0000_1111_00_0_0;
    localparam logic [11:0] O_LU    = 12'b1100_0100_00_0_0;
    localparam logic [11:0] O_IMISS = 12'b1000_1000_00_0_0;
    localparam logic [11:0] O_BR    = 12'b0000_1100_01_0_0;
    localparam logic [11:0] O_DW    = 12'b1111_0001_00_0_0;
    localparam logic [11:0] O_TO    = 12'b0000_1111_10_1_1;
    localparam logic [11:0] O_FL    = 12'b0000_1000_00_0_0;
    localparam logic [11:0] O_EXCAB = 12'b0000_1111_10_1_0;
    localparam logic [11:0] O_XRET  = 12'b0000_1111_11_0_0;

    logic [11:0] obs;
    assign obs = {stall_if, stall_ifid, stall_idex, stall_exmem,
                  clear_ifid, clear_idex, clear_exmem, clear_memwb,
                  pc_sel, dmem_abort, bus_err};

    hazard_ctrl #(.DMEM_TIMEOUT(8'd4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .imem_ack        (imem_ack),
        .mem_req         (mem_req),
        .dmem_ack        (dmem_ack),
        .wb_exc          (wb_exc),
        .wb_xret         (wb_xret),
        .stall_if        (stall_if),
        .stall_ifid      (stall_ifid),
        .stall_idex      (stall_idex),
        .stall_exmem     (stall_exmem),
        .clear_ifid      (clear_ifid),
        .clear_idex      (clear_idex),
        .clear_exmem     (clear_exmem),
        .clear_memwb     (clear_memwb),
        .pc_sel          (pc_sel),
        .dmem_abort      (dmem_abort),
        .bus_err         (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Sample settled outputs mid-cycle, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [11:0] exp);
        #1;
        chk(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst             = 1'b0;
        id_rs1          = 5'd1;
        id_rs2          = 5'd2;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        imem_ack        = 1'b1;
        mem_req         = 1'b0;
        dmem_ack        = 1'b0;
        wb_exc          = 4'd0;
        wb_xret         = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        cyc("reset", O_RST);
        idle();
        cyc("idle", O_IDLE);

        // Load-use via rs2, then via rs1, then ex_rd==0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        cyc("lu_rs2", O_LU);
        idle();
        cyc("lu_done", O_IDLE);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        cyc("lu_rs1", O_LU);
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_x0", O_IDLE);
        idle();

        // Fetch miss, branch, branch with fetch miss and load-use
        imem_ack = 1'b0;
        cyc("imiss", O_IMISS);
        idle();
        ex_branch_taken = 1'b1;
        cyc("branch", O_BR);
        idle();
        ex_branch_taken = 1'b1; imem_ack = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        cyc("br_miss_lu", O_BR);
        idle();

        // Data wait for 3 cycles then ack; back in RUN afterwards
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("dwait%0d", i), O_DW);
        dmem_ack = 1'b1;
        cyc("dwait_ack", O_IDLE);
        idle();
        ex_branch_taken = 1'b1;
        cyc("dwait_run", O_BR);
        idle();

        // Timeout at wcnt==4: entry + 3 waiting cycles, then bus error, FLUSH, RUN
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), O_DW);
        cyc("timeout", O_TO);
        cyc("to_flush", O_FL);
        idle();
        ex_branch_taken = 1'b1;
        cyc("to_run", O_BR);
        idle();

        // Ack in the timeout cycle wins, no bus error
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("ta_wait%0d", i), O_DW);
        dmem_ack = 1'b1;
        cyc("to_ack", O_IDLE);
        idle();
        ex_branch_taken = 1'b1;
        cyc("to_ack_run", O_BR);
        idle();

        // Trap priority: exception beats xret and branch; FLUSH ignores trap
        wb_exc = 4'h2; wb_xret = 1'b1; ex_branch_taken = 1'b1;
        mem_req = 1'b1; dmem_ack = 1'b1;
        cyc("trap_exc", O_EXCAB);
        cyc("trap_flush", O_FL);
        idle();
        wb_xret = 1'b1;
        cyc("trap_xret", O_XRET);
        idle();
        cyc("xret_flush", O_FL);
        cyc("post_xret", O_IDLE);

        // Trap while waiting on data memory aborts the access
        mem_req = 1'b1;
        cyc("dtrap_wait", O_DW);
        wb_exc = 4'h1;
        cyc("dtrap_exc", O_EXCAB);
        idle();
        cyc("dtrap_flush", O_FL);

        // Reset at DWAIT cycle 2, then a full timeout proves wcnt restarted at 0
        mem_req = 1'b1;
        cyc("rw_entry", O_DW);
        cyc("rw_wait1", O_DW);
        rst = 1'b1;
        cyc("rw_reset", O_RST);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("rw_wait_post%0d", i), O_DW);
        cyc("rw_timeout", O_TO);
        idle();
        cyc("rw_flush", O_FL);

        // Reset during FLUSH returns to RUN
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("rf_wait%0d", i), O_DW);
        cyc("rf_timeout", O_TO);
        idle();
        rst = 1'b1;
        cyc("rf_reset", O_RST);
        idle();
        imem_ack = 1'b0;
        cyc("rf_run", O_IMISS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
